uart_send_buffer: RTL and testbench
===================================

UART_SEND_BUFFER -- requirements
Module: uart_send_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries, power of two, minimum 2.
REQ-002 SHALL have parameter WIDTH, default 8, bits per entry.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_data  input  WIDTH  byte from the decode stage to send.
REQ-006 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  buffer can accept a byte this cycle.
REQ-008 SHALL have port flush  input  1  synchronous clear of FIFO contents and overflow.
REQ-009 SHALL have port tx_data  output  WIDTH  byte presented to the UART transmitter.
REQ-010 SHALL have port tx_start  output  1  one-cycle pulse requesting transmission of tx_data.
REQ-011 SHALL have port tx_busy  input  1  transmitter is shifting a byte.
REQ-012 SHALL have port count  output  log2(DEPTH)+1  number of bytes currently stored.
REQ-013 SHALL have port overflow  output  1  sticky flag: a byte was offered while full.

Function
REQ-014 SHALL store bytes in a DEPTH-entry circular FIFO with read/write pointers wrapping from DEPTH-1 to 0.
REQ-015 SHALL drive in_ready = (count < DEPTH), combinational from the registered count only.
REQ-016 SHALL push in_data when in_valid && in_ready at a rising edge.
REQ-017 SHALL leave the FIFO unchanged and set overflow when in_valid && !in_ready; overflow stays set until flush or reset.
REQ-018 SHALL implement a send FSM with states IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-019 In IDLE, if count > 0 and tx_busy = 0, SHALL pop the head byte into tx_data and move to START.
REQ-020 In START, SHALL assert tx_start for exactly that one cycle and move to WAIT_BUSY.
REQ-021 In WAIT_BUSY, SHALL move to WAIT_DONE on the first cycle tx_busy = 1.
REQ-022 In WAIT_DONE, SHALL move to IDLE on the first cycle tx_busy = 0.
REQ-023 Latency: byte pushed into an empty FIFO with FSM in IDLE and tx_busy = 0 SHALL give tx_start high two cycles after the push edge.
REQ-024 tx_data SHALL hold its value from the pop until the next pop.
REQ-025 On simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-026 When full, a simultaneous pop SHALL NOT admit a push in the same cycle (in_ready is already 0).
REQ-027 flush SHALL zero count and both pointers, clear overflow, and take priority over a same-cycle push or pop.
REQ-028 flush SHALL NOT alter FSM state, tx_data, or an in-flight tx_start.
REQ-029 count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-030 On rstn = 0, SHALL asynchronously set: FSM = IDLE, count = 0, pointers = 0, tx_data = 0, tx_start = 0, overflow = 0.
REQ-031 In reset, in_ready SHALL equal 1 because count = 0.
REQ-032 Reset asserted mid-transmission SHALL abandon the byte; FIFO contents SHALL be lost.
REQ-033 After rstn deasserts, SHALL accept a push on the first rising edge.

Verification
REQ-034 Push 0x41 into an empty FIFO with tx_busy = 0 -> tx_start pulses once, 2 cycles after the push, with tx_data = 0x41; count returns to 0.
REQ-035 Push 16 bytes 0x00..0x0F with tx_busy held 1 -> count = 16, in_ready = 0; a 17th offer sets overflow = 1 and count stays 16.
REQ-036 From full, release tx_busy and model a transmitter busy for 10 cycles per byte -> bytes leave in order 0x00..0x0F, one tx_start per byte, and the wrap of both pointers is exercised.
REQ-037 count = 3, with push and pop in the same cycle -> count stays 3, and the pushed byte is sent fourth.
REQ-038 flush with count = 5 and overflow = 1 while in WAIT_DONE -> count = 0, overflow = 0; the FSM finishes the current byte; no further tx_start occurs.
REQ-039 rstn pulsed low during WAIT_BUSY with count = 4 -> all outputs return to reset values immediately; no tx_start occurs after release until a new push.

Source files
------------

// File: rtl/uart_send_buffer.sv
// Byte FIFO that feeds a UART transmitter one byte at a time.
// A small send FSM pops the head byte, pulses tx_start and tracks tx_busy.
module uart_send_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [WIDTH-1:0]         tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_c;
  logic              pop_c;

  // Fullness depends only on the registered count, never on same-cycle pops.
  assign in_ready = (count < CW'(DEPTH));
  assign push_c   = in_valid && in_ready && !flush;

  // Send FSM: next state and pop request.
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if ((count != '0) && !tx_busy && !flush) begin
          pop_c   = 1'b1;
          state_d = START;
        end
      end
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Storage array carries no reset; validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Transmit-side registers are untouched by flush so an in-flight byte completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      tx_start <= (state_q == START);
      if (pop_c) begin
        tx_data <= mem[rd_ptr];
      end
    end
  end

  // Pointers, occupancy and sticky overflow; flush wins over push and pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_send_buffer.sv
// Directed bench for uart_send_buffer with a simple 10-cycle transmitter model.
module tb_uart_send_buffer;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [4:0] count;
  logic       overflow;

  logic       busy_hold;
  int         xmit_cnt = 0;
  int         n_starts = 0;
  logic [7:0] sent[$];

  int n_checks = 0;
  int n_fail   = 0;

  uart_send_buffer #(.DEPTH(16), .WIDTH(8)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Transmitter: busy for 10 cycles after each tx_start; logs every byte sent.
  assign tx_busy = busy_hold || (xmit_cnt != 0);
  always @(posedge clk) begin
    if (!rstn) begin
      xmit_cnt <= 0;
    end else if (tx_start) begin
      xmit_cnt <= 10;
      n_starts <= n_starts + 1;
      sent.push_back(tx_data);
    end else if (xmit_cnt != 0) begin
      xmit_cnt <= xmit_cnt - 1;
    end
  end

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       hold;
    logic [4:0] e_count;
    logic       e_ready;
    logic       e_start;
    logic [7:0] e_txd;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic v, logic [7:0] d, logic h, logic [4:0] c,
                              logic r, logic s, logic [7:0] t, logic o);
    vec_t x;
    x.valid = v; x.data = d; x.hold = h; x.e_count = c;
    x.e_ready = r; x.e_start = s; x.e_txd = t; x.e_ovf = o;
    vecs.push_back(x);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_byte(logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_sent(int n, int budget, string name);
    for (int c = 0; c < budget && sent.size() < n; c++) @(posedge clk);
    #1;
    check(name, 32'(sent.size()), 32'(n));
  endtask

  initial begin
    int base;
    bit found;

    rstn = 1'b0; in_data = '0; in_valid = 1'b0; flush = 1'b0; busy_hold = 1'b0;

    // Single byte into an empty FIFO: tx_start two edges after the push.
    add(1'b1, 8'h41, 1'b0, 5'd1, 1'b1, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'h41, 1'b0);
    add(1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'h41, 1'b0);
    for (int i = 3; i < 20; i++) add(1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'h41, 1'b0);
    // Fill to full with the transmitter held busy, then offer one more.
    for (int i = 0; i < 16; i++)
      add(1'b1, 8'(i), 1'b1, 5'(i + 1), (i + 1 < 16), 1'b0, 8'h41, 1'b0);
    add(1'b1, 8'hAA, 1'b1, 5'd16, 1'b0, 1'b0, 8'h41, 1'b1);
    add(1'b0, 8'h00, 1'b1, 5'd16, 1'b0, 1'b0, 8'h41, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in_valid  = vecs[i].valid;
      in_data   = vecs[i].data;
      busy_hold = vecs[i].hold;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
      check($sformatf("v%0d_tx_start", i), 32'(tx_start), 32'(vecs[i].e_start));
      check($sformatf("v%0d_tx_data", i), 32'(tx_data), 32'(vecs[i].e_txd));
      check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
    end
    check("single_byte_starts", 32'(n_starts), 32'd1);

    // Drain a full FIFO: order preserved, pointers wrap.
    sent.delete();
    base = n_starts;
    @(negedge clk);
    in_valid  = 1'b0;
    busy_hold = 1'b0;
    wait_sent(16, 600, "drain_done");
    for (int i = 0; i < 16; i++)
      check($sformatf("drain_byte%0d", i),
            (i < sent.size()) ? 32'(sent[i]) : 32'hFFFF_FFFF, 32'(i));
    idle(20);
    check("drain_starts", 32'(n_starts - base), 32'd16);
    check("drain_count", 32'(count), 32'd0);
    check("drain_ovf_sticky", 32'(overflow), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    flush = 1'b0;

    // Simultaneous push and pop at count 3.
    sent.delete();
    @(negedge clk);
    busy_hold = 1'b1;
    push_byte(8'h10);
    push_byte(8'h11);
    push_byte(8'h12);
    check("pp_pre_count", 32'(count), 32'd3);
    @(negedge clk);
    busy_hold = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h13;
    @(posedge clk);
    #1;
    check("pp_count", 32'(count), 32'd3);
    check("pp_tx_data", 32'(tx_data), 32'h10);
    @(negedge clk);
    in_valid = 1'b0;
    wait_sent(4, 200, "pp_done");
    for (int i = 0; i < 4; i++)
      check($sformatf("pp_byte%0d", i),
            (i < sent.size()) ? 32'(sent[i]) : 32'hFFFF_FFFF, 32'h10 + 32'(i));
    idle(20);

    // Flush during WAIT_DONE with count 5 and overflow set.
    busy_hold = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    push_byte(8'hEE);
    check("fl_full_count", 32'(count), 32'd16);
    check("fl_overflow", 32'(overflow), 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    busy_hold = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(posedge clk);
      #1;
      if (tx_start && count == 5'd5) found = 1'b1;
    end
    check("fl_reach_count5", 32'(found), 32'd1);
    check("fl_tx_data", 32'(tx_data), 32'h2A);
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    base = n_starts;
    check("fl_count", 32'(count), 32'd0);
    check("fl_ovf_clear", 32'(overflow), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    check("fl_tx_data_kept", 32'(tx_data), 32'h2A);
    @(negedge clk);
    flush = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("fl_no_more_starts", 32'(n_starts - base), 32'd0);

    // Reset asserted in WAIT_BUSY with count 4.
    @(negedge clk);
    busy_hold = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i));
    @(negedge clk);
    in_valid  = 1'b0;
    busy_hold = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(posedge clk);
      #1;
      if (tx_start) found = 1'b1;
    end
    check("rb_start_seen", 32'(found), 32'd1);
    check("rb_count", 32'(count), 32'd4);
    #1 rstn = 1'b0;
    #1;
    check("rb_count_rst", 32'(count), 32'd0);
    check("rb_in_ready", 32'(in_ready), 32'd1);
    check("rb_tx_start", 32'(tx_start), 32'd0);
    check("rb_tx_data", 32'(tx_data), 32'd0);
    check("rb_overflow", 32'(overflow), 32'd0);
    base = n_starts;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("rb_no_start", 32'(n_starts - base), 32'd0);
    check("rb_count_after", 32'(count), 32'd0);

    // Push accepted on the first edge after reset release.
    @(negedge clk);
    rstn = 1'b0;
    #2;
    in_valid = 1'b1;
    in_data  = 8'h66;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("rr_count", 32'(count), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rr_tx_start_early", 32'(tx_start), 32'd0);
    @(posedge clk);
    #1;
    check("rr_tx_start", 32'(tx_start), 32'd1);
    check("rr_tx_data", 32'(tx_data), 32'h66);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
